// File: rtl/sd_sector_responder_if.sv
// Sector-transfer handshake between a requester (backup-RAM load/save logic)
// and a responder that serves 512-byte sectors. The requester owns a
// registered byte buffer addressed by sd_buff_addr.
interface sd_sector_responder_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;

    // Requester side: issues sector requests and owns the sector buffer.
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    // Responder side: acknowledges requests and moves bytes.
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Sector responder: serves 512-byte read/write sector requests from a
// byte-wide backing image memory with a request/ready handshake.
// Requests beyond the image (or beyond the addressable sectors) still run
// the full byte sequence, but read zeros / discard writes and raise err.
module sd_sector_responder #(
    parameter int IMG_AW    = 15,
    parameter int ACK_DELAY = 4
) (
    input  logic                  clk_sys,
    input  logic                  RESET_n,
    sd_sector_responder_if.slave  sd,
    input  logic [63:0]           img_size,
    output logic [IMG_AW-1:0]     img_addr,
    output logic                  img_rd,
    output logic                  img_wr,
    output logic [7:0]            img_wdata,
    input  logic [7:0]            img_rdata,
    input  logic                  img_ready,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, ACKWAIT, RD_FETCH, RD_PUT, WR_ADDR, WR_LAT, WR_STORE, DONE
    } state_t;

    localparam int          SEC_AW  = IMG_AW - 9;
    localparam int          LBA_W   = (SEC_AW > 0) ? SEC_AW : 1;
    localparam int          DLY_W   = $clog2(ACK_DELAY) + 1;
    localparam logic [63:0] SECTORS = 64'd1 << SEC_AW;

    state_t             state, state_nxt;
    logic [DLY_W-1:0]   dly_cnt;
    logic [8:0]         idx;
    logic [LBA_W-1:0]   lba_q;
    logic               dir_rd;
    logic               oor_q;
    logic               ack_q;
    logic [8:0]         buff_addr_q;
    logic [7:0]         buff_dout_q;
    logic               buff_wr_q;
    logic [7:0]         wdata_q;
    logic               err_q;

    logic               req;
    logic [63:0]        sector_end;
    logic               oor_now;
    logic               access_done;
    logic               last_byte;
    logic               dly_done;

    assign req         = sd.sd_rd | sd.sd_wr;
    assign sector_end  = ({32'd0, sd.sd_lba} + 64'd1) << 9;
    assign oor_now     = ({32'd0, sd.sd_lba} >= SECTORS) || (sector_end > img_size);
    // An out-of-range sector never touches the image, so each byte step
    // completes without waiting for img_ready.
    assign access_done = oor_q || img_ready;
    assign last_byte   = (idx == 9'd511);
    assign dly_done    = (dly_cnt == DLY_W'(ACK_DELAY - 1));

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode.
    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req) state_nxt = ACKWAIT;
            ACKWAIT:  if (dly_done) state_nxt = dir_rd ? RD_FETCH : WR_ADDR;
            RD_FETCH: if (access_done) state_nxt = RD_PUT;
            RD_PUT:   state_nxt = last_byte ? DONE : RD_FETCH;
            WR_ADDR:  state_nxt = WR_LAT;
            WR_LAT:   state_nxt = WR_STORE;
            WR_STORE: if (access_done) state_nxt = last_byte ? DONE : WR_ADDR;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request latching, byte counter and registered handshake outputs.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            dly_cnt     <= '0;
            idx         <= '0;
            lba_q       <= '0;
            dir_rd      <= 1'b0;
            oor_q       <= 1'b0;
            ack_q       <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lba_q   <= sd.sd_lba[LBA_W-1:0];
                        dir_rd  <= sd.sd_rd;
                        oor_q   <= oor_now;
                        err_q   <= 1'b0;
                        dly_cnt <= '0;
                    end
                end
                ACKWAIT: begin
                    if (dly_done) begin
                        ack_q <= 1'b1;
                        idx   <= '0;
                        err_q <= oor_q;
                        // The write path presents byte 0 to the requester buffer first.
                        if (!dir_rd) buff_addr_q <= '0;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                RD_FETCH: begin
                    if (access_done) begin
                        buff_wr_q   <= 1'b1;
                        buff_addr_q <= idx;
                        buff_dout_q <= oor_q ? 8'h00 : img_rdata;
                    end
                end
                RD_PUT: begin
                    buff_wr_q <= 1'b0;
                    if (last_byte) ack_q <= 1'b0;
                    else           idx   <= idx + 9'd1;
                end
                WR_LAT: begin
                    // Requester buffer is registered: data for buff_addr is valid now.
                    wdata_q <= sd.sd_buff_din;
                end
                WR_STORE: begin
                    if (access_done) begin
                        if (last_byte) begin
                            ack_q <= 1'b0;
                        end else begin
                            idx         <= idx + 9'd1;
                            buff_addr_q <= idx + 9'd1;
                        end
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

    generate
        if (SEC_AW > 0) begin : g_addr_lba
            assign img_addr = {lba_q, idx};
        end else begin : g_addr_single
            assign img_addr = idx;
        end
    endgenerate

    assign img_rd          = (state == RD_FETCH) && !oor_q;
    assign img_wr          = (state == WR_STORE) && !oor_q;
    assign img_wdata       = wdata_q;
    assign busy            = (state != IDLE);
    assign err             = err_q;

    assign sd.sd_ack       = ack_q;
    assign sd.sd_buff_addr = buff_addr_q;
    assign sd.sd_buff_dout = buff_dout_q;
    assign sd.sd_buff_wr   = buff_wr_q;

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Responder side of the sector-transfer handshake used by the backup-RAM load/save logic (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Serves 512-byte sector requests from a byte-wide backing image memory. Used for simulation benches and a local save-image store, in place of the HPS link.
- A read request streams one sector from the image into the requester's buffer. A write request pulls one sector from the requester's buffer into the image.

Parameters:
- IMG_AW, 15, image byte-address width. 2^IMG_AW bytes = 2^(IMG_AW-9) sectors. Must be >= 9.
- ACK_DELAY, 4, clk_sys cycles from request acceptance to sd_ack rise. Must be >= 1.

Ports:
- clk_sys in 1: system clock, all logic on posedge.
- RESET_n in 1: reset, asynchronous, active-low.
- sd_lba in 32: sector number, sampled at request acceptance.
- sd_rd in 1: read-sector request (level).
- sd_wr in 1: write-sector request (level).
- sd_ack out 1: transfer in progress.
- sd_buff_addr out 9: byte index within the sector.
- sd_buff_dout out 8: read data to the requester buffer.
- sd_buff_din in 8: requester buffer data; valid 1 cycle after sd_buff_addr changes (registered RAM).
- sd_buff_wr out 1: write strobe into the requester buffer.
- img_size in 64: image length in bytes; 0 means no image.
- img_addr out IMG_AW: backing memory address.
- img_rd out 1: backing read request; held until img_ready.
- img_wr out 1: backing write request; held until img_ready.
- img_wdata out 8: backing write data.
- img_rdata in 8: backing read data; valid in the img_ready cycle.
- img_ready in 1: backing access complete.
- busy out 1: state != IDLE.
- err out 1: sticky out-of-range flag for the current or last request.

Behaviour:
- Reset (async, RESET_n=0): all outputs 0, state IDLE, byte counter 0, latched LBA 0. Reset mid-transfer aborts immediately. No further img_* strobes occur. The partially written image is left as-is.
- States: IDLE, ACKWAIT, RD_FETCH, RD_PUT, WR_ADDR, WR_LAT, WR_STORE, DONE.
- IDLE:
  - If sd_rd|sd_wr is 1, accept the request: latch sd_lba and the direction (sd_rd wins when both are set), clear err, go to ACKWAIT.
  - Out-of-range check at accept: flag set if sd_lba >= 2^(IMG_AW-9), or (sd_lba+1)*512 > img_size.
- ACKWAIT: count ACK_DELAY cycles. Then assert sd_ack and set the counter i=0. Go to RD_FETCH (read) or WR_ADDR (write). If out of range, set err=1.
- sd_ack stays 1 from ACKWAIT exit until the cycle after the final byte completes. Requests sampled while busy are ignored; the requester drops its request on sd_ack rise.
- Read path:
  - RD_FETCH: img_addr={lba[IMG_AW-10:0],i}, img_rd=1 until img_ready. Out of range: no img_rd, byte=0x00, advance next cycle.
  - RD_PUT: one cycle with sd_buff_wr=1, sd_buff_addr=i, sd_buff_dout=byte.
  - i<511: i++, back to RD_FETCH. i=511: DONE.
- Write path:
  - WR_ADDR: sd_buff_addr=i.
  - WR_LAT: capture sd_buff_din into img_wdata.
  - WR_STORE: img_addr as above, img_wr=1 until img_ready. Out of range: no img_wr, byte discarded.
  - i<511: i++, WR_ADDR. i=511: DONE.
- DONE: sd_ack=0, sd_buff_wr=0, one cycle, then IDLE. A request level already present in DONE is accepted on the following IDLE cycle. This supports back-to-back sectors where the requester raises the next sd_rd/sd_wr on the sd_ack falling edge.
- Counter is 9 bits; 511->0 wrap occurs only at DONE. sd_buff_addr holds its last value outside transfers.
- img_rd and img_wr are never asserted together. img_addr and img_wdata are stable while a request is held.
- img_ready outside a pending request is ignored.

Test Plan:
- Image byte k = k[7:0], img_size=32768, img_ready same cycle. sd_rd with lba=0 -> sd_ack rises ACK_DELAY cycles after accept; 512 sd_buff_wr pulses, addr 0..511, dout = addr[7:0]; sd_ack falls after addr 511.
- Requester buffer preloaded with 0xA5^addr. sd_wr with lba=5 -> image bytes 2560..3071 equal 0xA5^(k-2560); no other image byte changes; err=0.
- Requester loop as in backup load, lba 0..63 issued on each sd_ack fall -> 64 transfers, no sector skipped or repeated, 32768 buffer writes total.
- sd_rd with lba=64 (IMG_AW=15) or img_size=1024 with lba=2 -> err=1; 512 writes of 0x00; zero img_rd strobes. A following in-range sd_wr clears err.
- img_ready delayed by a random 0..7 cycles -> data identical to the first two scenarios; img_addr stable while img_rd/img_wr is held.
- RESET_n low at byte 200 of a read -> all outputs 0 asynchronously. After release, a new lba=1 read completes correctly from addr 0.
